intr_src: RTL and testbench

Machine-level interrupt source placed directly upstream of the CSR register file. It holds a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare register, both memory-mapped on a simple request/acknowledge bus. It raises the timer-interrupt level `t_intr_o` that feeds the CSR `t_intr` input. It also synchronises the asynchronous external interrupt pin into a single-cycle `e_intr_o` pulse that feeds the CSR `e_intr` input.

---
 rtl/intr_src.sv | 134 +++++++++++++
 tb/tb_intr_src.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_src.sv
// Machine timer/external interrupt source feeding the CSR file.
// Holds mtime/mtimecmp/ctrl on a one-cycle req/ack register bus.
module intr_src #(
  parameter int DW          = 32,
  parameter int PRESC_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [4:0]    addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          ack_o,
  output logic [DW-1:0] rdata_o,
  input  logic          ext_irq_i,
  output logic          t_intr_o,
  output logic          e_intr_o
);

  logic [63:0]            mtime;
  logic [63:0]            mtimecmp;
  logic                   ten;
  logic                   een;
  logic [PRESC_W-1:0]     presc;
  logic [PRESC_W-1:0]     presc_cnt;
  logic [31:0]            hi_shadow;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  logic [2:0]    sel;
  logic          wr;
  logic          rd;
  logic          hit_mlo;
  logic          hit_mhi;
  logic          hit_clo;
  logic          hit_chi;
  logic          hit_ctl;
  logic          tick;
  logic [DW-1:0] ctrl_val;
  logic [DW-1:0] rd_val;
  logic          unused_addr;

  // Word select only; byte offset within a word is don't-care.
  assign sel         = addr_i[4:2];
  assign unused_addr = ^addr_i[1:0];
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign hit_mlo     = (sel == 3'd0);
  assign hit_mhi     = (sel == 3'd1);
  assign hit_clo     = (sel == 3'd2);
  assign hit_chi     = (sel == 3'd3);
  assign hit_ctl     = (sel == 3'd4);
  assign tick        = (presc_cnt == presc);

  // Assemble ctrl read view; undefined bits read zero.
  always_comb begin
    ctrl_val             = '0;
    ctrl_val[0]          = ten;
    ctrl_val[1]          = een;
    ctrl_val[8+:PRESC_W] = presc;
  end

  // Read mux on pre-edge register values; hi returns the shadow.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_mlo: rd_val = mtime[31:0];
      hit_mhi: rd_val = hi_shadow;
      hit_clo: rd_val = mtimecmp[31:0];
      hit_chi: rd_val = mtimecmp[63:32];
      hit_ctl: rd_val = ctrl_val;
      default: rd_val = '0;
    endcase
  end

  // Bus response, hi shadow capture, compare and ctrl registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o     <= 1'b0;
      rdata_o   <= '0;
      hi_shadow <= '0;
      mtimecmp  <= '1;
      ten       <= 1'b0;
      een       <= 1'b0;
      presc     <= '0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= rd ? rd_val : '0;
      if (rd && hit_mlo) hi_shadow <= mtime[63:32];
      if (wr && hit_clo) mtimecmp[31:0]  <= wdata_i;
      if (wr && hit_chi) mtimecmp[63:32] <= wdata_i;
      if (wr && hit_ctl) begin
        ten   <= wdata_i[0];
        een   <= wdata_i[1];
        presc <= wdata_i[8+:PRESC_W];
      end
    end
  end

  // Prescaler and mtime; a half write suppresses that cycle's tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt <= '0;
      mtime     <= '0;
    end else begin
      if ((wr && hit_ctl) || tick) presc_cnt <= '0;
      else                         presc_cnt <= presc_cnt + 1'b1;
      if (wr && hit_mlo)      mtime[31:0]  <= wdata_i;
      else if (wr && hit_mhi) mtime[63:32] <= wdata_i;
      else if (tick)          mtime        <= mtime + 64'd1;
    end
  end

  // Registered timer level from current mtime/mtimecmp.
  always_ff @(posedge clk_i) begin
    if (rst_i) t_intr_o <= 1'b0;
    else       t_intr_o <= ten && (mtime >= mtimecmp);
  end

  // Synchronise ext pin, then one-cycle pulse on rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      edge_q   <= 1'b0;
      e_intr_o <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
      edge_q   <= sync_q[SYNC_STAGES-1];
      e_intr_o <= een & sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

endmodule

// File: tb/tb_intr_src.sv
// Randomised + directed bench for intr_src.
// Scoreboard of expected bus responses; model tracks timer and ext pulse.
module tb_intr_src;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ext;
  logic        ack;
  logic [31:0] rdata;
  logic        t_intr;
  logic        e_intr;

  int checks = 0;
  int fails  = 0;

  // bit 32: compare data (read), bits 31:0 expected rdata
  logic [32:0] sb[$];

  // reference model state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  bit          m_ten;
  bit          m_een;
  int          m_presc;
  int          m_phase;
  logic [31:0] m_sh;
  bit          m_t;
  bit          m_e;
  logic [7:0]  hist;
  bit          ext_lvl;

  intr_src dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .ack_o     (ack),
    .rdata_o   (rdata),
    .ext_irq_i (ext),
    .t_intr_o  (t_intr),
    .e_intr_o  (e_intr)
  );

  always #5 clk = ~clk;

  // monitor: every bus response is matched against the scoreboard
  always @(negedge clk) begin
    logic [32:0] e;
    if (ack === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected: ack=1 with no request pending t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (e[32] && rdata !== e[31:0]) begin
          fails++;
          $display("FAIL rdata: got %h expected %h t=%0t", rdata, e[31:0], $time);
        end
      end
    end else begin
      checks++;
      if (sb.size() != 0 || rdata !== 32'h0 || ack !== 1'b0) begin
        fails++;
        $display("FAIL idle_bus: ack=%b rdata=%h pending=%0d required ack=%b rdata=0",
                 ack, rdata, sb.size(), sb.size() != 0);
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
  end

  function automatic logic [31:0] reg_view(input logic [2:0] s);
    logic [31:0] v;
    v = 32'h0;
    case (s)
      3'd0: v = m_time[31:0];
      3'd1: v = m_sh;
      3'd2: v = m_cmp[31:0];
      3'd3: v = m_cmp[63:32];
      3'd4: begin
        v[0]    = m_ten;
        v[1]    = m_een;
        v[15:8] = m_presc[7:0];
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  // one clock: drive, apply spec rules at the edge, check levels
  task automatic cyc(input bit r, input bit q, input bit w,
                     input logic [4:0] a, input logic [31:0] d);
    logic [2:0] s;
    bit         nt;
    bit         ne;
    bit         tk;
    rst   = r;
    req   = q;
    we    = w;
    addr  = a;
    wdata = d;
    ext   = ext_lvl;
    @(posedge clk);
    s = a[4:2];
    if (r) begin
      m_time  = 64'h0;
      m_cmp   = '1;
      m_ten   = 0;
      m_een   = 0;
      m_presc = 0;
      m_phase = 0;
      m_sh    = 32'h0;
      m_t     = 0;
      m_e     = 0;
      hist    = 8'h0;
    end else begin
      nt = m_ten && (m_time >= m_cmp);
      ne = m_een && hist[SYNC-1] && !hist[SYNC];
      hist = {hist[6:0], ext_lvl};
      if (q) sb.push_back({!w, (w ? 32'h0 : reg_view(s))});
      if (q && !w && s == 3'd0) m_sh = m_time[63:32];
      tk = (m_phase == m_presc);
      m_phase = tk ? 0 : m_phase + 1;
      if (q && w && s == 3'd0)      m_time[31:0]  = d;
      else if (q && w && s == 3'd1) m_time[63:32] = d;
      else if (tk)                  m_time        = m_time + 64'd1;
      if (q && w && s == 3'd2) m_cmp[31:0]  = d;
      if (q && w && s == 3'd3) m_cmp[63:32] = d;
      if (q && w && s == 3'd4) begin
        m_ten   = d[0];
        m_een   = d[1];
        m_presc = int'(d[15:8]);
        m_phase = 0;
      end
      m_t = nt;
      m_e = ne;
    end
    @(negedge clk);
    checks++;
    if (t_intr !== m_t) begin
      fails++;
      $display("FAIL t_intr: got %b expected %b t=%0t", t_intr, m_t, $time);
    end
    checks++;
    if (e_intr !== m_e) begin
      fails++;
      $display("FAIL e_intr: got %b expected %b t=%0t", e_intr, m_e, $time);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(0, 1, 1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    cyc(0, 1, 0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'h0, 32'h0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 5'h0, 32'h0);
    cyc(1, 0, 0, 5'h0, 32'h0);
  endtask

  initial begin
    ext_lvl = 0;
    do_reset();

    // reset view; hi before any lo read must be zero
    rd(5'h04); rd(5'h00); rd(5'h08); rd(5'h0C); rd(5'h10); rd(5'h18);

    // prescaler 3 with timer enabled
    wr(5'h10, 32'h0000_0301);
    idle(40);
    rd(5'h00); rd(5'h04);

    // carry into hi and tear-free shadow
    wr(5'h10, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'hFFFF_FFFE);
    idle(1);
    rd(5'h00); rd(5'h04);

    // timer compare rise, raise cmp, clear TEN
    wr(5'h10, 32'h1);
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'd100);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'd90);
    idle(15);
    wr(5'h08, 32'hFFFF_FFFF);
    idle(3);
    wr(5'h08, 32'd50);
    idle(3);
    wr(5'h10, 32'h0);
    idle(3);
    wr(5'h00, 32'd10);
    rd(5'h00);

    // external edge with EEN set, then with EEN clear
    wr(5'h10, 32'h2);
    ext_lvl = 1; idle(10);
    ext_lvl = 0; idle(4);
    wr(5'h10, 32'h0);
    ext_lvl = 1; idle(10);
    ext_lvl = 0; idle(4);

    // mtime_lo write against a tick (PRESC=0 ticks every cycle)
    wr(5'h00, 32'd5);
    rd(5'h00);
    wr(5'h10, 32'h0000_0100);
    idle(1);
    wr(5'h00, 32'd77);
    rd(5'h00); rd(5'h01);

    // unmapped read/write
    wr(5'h18, 32'hDEAD_BEEF);
    rd(5'h18); rd(5'h1F); rd(5'h14);

    // reset right after a read, and a request sampled in reset
    rd(5'h00);
    cyc(1, 0, 0, 5'h0, 32'h0);
    cyc(1, 1, 0, 5'h08, 32'h0);
    rd(5'h08); rd(5'h10);

    // randomised traffic
    for (int i = 0; i < 2500; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      bit          q;
      bit          w;
      if ($urandom_range(0, 7) == 0) ext_lvl = !ext_lvl;
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      if (a[4:2] == 3'd4) d[15:8] = 8'($urandom_range(0, 3));
      if (a[4:2] != 3'd4 && $urandom_range(0, 1) == 1)
        d = 32'($urandom_range(0, 300));
      q = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) cyc(1, q, w, a, d);
      else                              cyc(0, q, w, a, d);
    end

    idle(3);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
